// File: rtl/axi_rd_arbiter_if.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter_if
//
// One AXI4 read channel (AR + R) as seen by the read arbiter. The arbiter uses
// three instances of this interface: one per requester (IFU, LSU) on the
// subordinate side and one toward the core's io_master read port.
//
// Payload packing:
//   ar = {addr[ADDR_W-1:0], id[ID_W-1:0], len[7:0], size[2:0], burst[1:0]}
//   r  = {data[DATA_W-1:0], id[ID_W-1:0], last, resp[1:0]}
//
// Signals:
//   arvalid / arready / ar   address request handshake and payload
//   rvalid  / rready  / r    read data handshake and payload
//
// Modports:
//   master  drives the request (arvalid, ar, rready)
//   slave   answers it (arready, rvalid, r)
// -----------------------------------------------------------------------------
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  localparam int AR_W = ADDR_W + ID_W + 13;
  localparam int R_W  = DATA_W + ID_W + 3;

  logic            arvalid;
  logic            arready;
  logic [AR_W-1:0] ar;
  logic            rvalid;
  logic            rready;
  logic [R_W-1:0]  r;

  modport master (
    output arvalid, ar, rready,
    input  arready, rvalid, r
  );

  modport slave (
    input  arvalid, ar, rready,
    output arready, rvalid, r
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares the core's single AXI4 read channel between the instruction fetch unit
// (4-beat INCR bursts) and the load/store unit (single beats). Exactly one
// transaction is outstanding at a time; the grant is held from arbitration
// until the last R beat, so beats of different transactions never interleave.
//
// Arbitration takes one cycle in IDLE: a request seen in cycle N shows up as
// io_master.arvalid in cycle N+1. After the last beat the block spends one
// IDLE cycle before the next grant (no back-to-back bypass). Payloads pass
// through combinationally; there is no data pipeline register.
//
// Ports:
//   clock      single clock
//   reset      synchronous, active-high; aborts any transaction without drain
//   ifu        IFU read port (slave modport of axi_rd_arbiter_if)
//   lsu        LSU read port (slave modport of axi_rd_arbiter_if)
//   io_master  shared bus read port (master modport of axi_rd_arbiter_if)
//   grant      01 = IFU, 10 = LSU, 00 = none
//   busy       high whenever the FSM is outside IDLE
//
// Build option:
//   AXI_RD_ARB_RR_EN  when defined, a simultaneous request in IDLE goes to the
//                     requester that did not win the previous grant (the
//                     last-winner register resets to LSU, so IFU wins the first
//                     tie). When undefined, LSU has fixed priority and no
//                     last-winner register exists.
// -----------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  axi_rd_arbiter_if.slave         ifu,
  axi_rd_arbiter_if.slave         lsu,
  axi_rd_arbiter_if.master        io_master,
  output logic [1:0]              grant,
  output logic                    busy
);

  localparam int AR_W       = ADDR_W + ID_W + 13;
  localparam int R_W        = DATA_W + ID_W + 3;
  localparam int R_LAST_BIT = 2;   // r = {data, id, last, resp[1:0]}

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_IFU  = 2'b01;
  localparam logic [1:0] GRANT_LSU  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR_IFU,
    S_AR_LSU,
    S_R_IFU,
    S_R_LSU
  } state_t;

  state_t          state;
  logic [R_W-1:0]  bus_r;
  logic            bus_last;
  logic            ifu_wins_tie;
  logic            pick_ifu;
  logic            pick_lsu;

  assign bus_r    = io_master.r;
  assign bus_last = bus_r[R_LAST_BIT];

  // Both requesters always see the bus R payload; only rvalid is steered.
  assign ifu.r = bus_r;
  assign lsu.r = bus_r;

  // ---------------------------------------------------------------------------
  // Tie-break between simultaneous IDLE requests.
  // ---------------------------------------------------------------------------
`ifdef AXI_RD_ARB_RR_EN
  logic last_win_lsu;   // 1: LSU won the most recent grant

  assign ifu_wins_tie = last_win_lsu;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_win_lsu <= 1'b1;
    end else if (state == S_IDLE) begin
      if (pick_ifu) begin
        last_win_lsu <= 1'b0;
      end else if (pick_lsu) begin
        last_win_lsu <= 1'b1;
      end
    end
  end
`else
  assign ifu_wins_tie = 1'b0;
`endif

  // Winner of this IDLE cycle's arbitration (only meaningful in IDLE).
  assign pick_ifu = ifu.arvalid && (!lsu.arvalid || ifu_wins_tie);
  assign pick_lsu = lsu.arvalid && !pick_ifu;

  // ---------------------------------------------------------------------------
  // Control FSM: state, grant and busy are all registered here.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, exactly like the hardware does.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      grant <= GRANT_NONE;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pick_ifu) begin
            state <= S_AR_IFU;
            grant <= GRANT_IFU;
            busy  <= 1'b1;
          end else if (pick_lsu) begin
            state <= S_AR_LSU;
            grant <= GRANT_LSU;
            busy  <= 1'b1;
          end
        end

        // A granted requester that withdraws arvalid before the handshake
        // (IFU flush on a control hazard) simply releases the bus.
        S_AR_IFU: begin
          if (ifu.arvalid && io_master.arready) begin
            state <= S_R_IFU;
          end else if (!ifu.arvalid) begin
            state <= S_IDLE;
            grant <= GRANT_NONE;
            busy  <= 1'b0;
          end
        end

        S_AR_LSU: begin
          if (lsu.arvalid && io_master.arready) begin
            state <= S_R_LSU;
          end else if (!lsu.arvalid) begin
            state <= S_IDLE;
            grant <= GRANT_NONE;
            busy  <= 1'b0;
          end
        end

        // Grant is released only by the beat that carries last.
        S_R_IFU: begin
          if (io_master.rvalid && ifu.rready && bus_last) begin
            state <= S_IDLE;
            grant <= GRANT_NONE;
            busy  <= 1'b0;
          end
        end

        S_R_LSU: begin
          if (io_master.rvalid && lsu.rready && bus_last) begin
            state <= S_IDLE;
            grant <= GRANT_NONE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          grant <= GRANT_NONE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake steering. Everything here is a pure function of the registered
  // state and the live handshake inputs.
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case so no path through the
  // block leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    ifu.arready       = 1'b0;
    lsu.arready       = 1'b0;
    ifu.rvalid        = 1'b0;
    lsu.rvalid        = 1'b0;
    io_master.arvalid = 1'b0;
    io_master.ar      = {AR_W{1'b0}};
    io_master.rready  = 1'b0;

    unique case (state)
      S_AR_IFU: begin
        io_master.arvalid = ifu.arvalid;
        io_master.ar      = ifu.ar;
        ifu.arready       = io_master.arready;
      end
      S_AR_LSU: begin
        io_master.arvalid = lsu.arvalid;
        io_master.ar      = lsu.ar;
        lsu.arready       = io_master.arready;
      end
      S_R_IFU: begin
        io_master.rready = ifu.rready;
        ifu.rvalid       = io_master.rvalid;
      end
      S_R_LSU: begin
        io_master.rready = lsu.rready;
        lsu.rvalid       = io_master.rvalid;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter
//
// Directed scenarios followed by randomized traffic. Every cycle, all DUT
// outputs are compared against a transaction-level reference model that tracks
// only "who owns the bus" and "address or data phase".
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int AR_W   = ADDR_W + ID_W + 13;
  localparam int R_W    = DATA_W + ID_W + 3;

  localparam int NONE = -1;
  localparam int IFU  = 0;
  localparam int LSU  = 1;

`ifdef AXI_RD_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif
  localparam logic [1:0] TIE_FIRST  = RR_EN ? 2'b01 : 2'b10;
  localparam logic [1:0] TIE_SECOND = RR_EN ? 2'b10 : 2'b01;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] grant;
  logic       busy;

  axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) ifu_bus ();
  axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) lsu_bus ();
  axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) mem_bus ();

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .ifu       (ifu_bus),
    .lsu       (lsu_bus),
    .io_master (mem_bus),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: owner of the bus and whether its address is still pending.
  int owner    = NONE;
  bit in_addr  = 1'b0;
  int last_win = LSU;

  // Data words the DUT actually handed to IFU (observed rvalid & rready).
  logic [DATA_W-1:0] ifu_got[$];

  function automatic logic [AR_W-1:0] mk_ar(input logic [31:0] addr, input logic [7:0] len);
    return {addr, 4'h1, len, 3'd2, 2'b01};
  endfunction

  function automatic logic [R_W-1:0] mk_r(input logic [31:0] data, input logic last);
    return {data, 4'h1, last, 2'b00};
  endfunction

  task automatic idle_inputs();
    ifu_bus.arvalid = 1'b0; ifu_bus.ar = '0; ifu_bus.rready = 1'b0;
    lsu_bus.arvalid = 1'b0; lsu_bus.ar = '0; lsu_bus.rready = 1'b0;
    mem_bus.arready = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.r = '0;
  endtask

  // One clock: compare at the falling edge, advance the model, return 1ns after
  // the rising edge so callers drive new inputs away from the edge.
  task automatic tick();
    logic [1:0]      arv, rrd, e_arready, e_rvalid, e_grant;
    logic [AR_W-1:0] arp[2];
    logic [AR_W-1:0] e_io_ar;
    logic            e_io_arvalid, e_io_rready;
    @(negedge clock);
    arv    = {lsu_bus.arvalid, ifu_bus.arvalid};
    rrd    = {lsu_bus.rready, ifu_bus.rready};
    arp[0] = ifu_bus.ar;
    arp[1] = lsu_bus.ar;
    e_arready = 2'b00; e_rvalid = 2'b00; e_grant = 2'b00;
    e_io_ar = '0; e_io_arvalid = 1'b0; e_io_rready = 1'b0;
    if (owner != NONE) begin
      e_grant = (owner == IFU) ? 2'b01 : 2'b10;
      if (in_addr) begin
        e_io_arvalid     = arv[owner];
        e_io_ar          = arp[owner];
        e_arready[owner] = mem_bus.arready;
      end else begin
        e_io_rready     = rrd[owner];
        e_rvalid[owner] = mem_bus.rvalid;
      end
    end
    check("grant",        64'(grant),             64'(e_grant));
    check("busy",         64'(busy),              64'(owner != NONE));
    check("ifu_arready",  64'(ifu_bus.arready),   64'(e_arready[IFU]));
    check("lsu_arready",  64'(lsu_bus.arready),   64'(e_arready[LSU]));
    check("ifu_rvalid",   64'(ifu_bus.rvalid),    64'(e_rvalid[IFU]));
    check("lsu_rvalid",   64'(lsu_bus.rvalid),    64'(e_rvalid[LSU]));
    check("io_arvalid",   64'(mem_bus.arvalid),   64'(e_io_arvalid));
    check("io_ar",        64'(mem_bus.ar),        64'(e_io_ar));
    check("io_rready",    64'(mem_bus.rready),    64'(e_io_rready));
    check("ifu_r",        64'(ifu_bus.r),         64'(mem_bus.r));
    check("lsu_r",        64'(lsu_bus.r),         64'(mem_bus.r));
    if (ifu_bus.rvalid === 1'b1 && ifu_bus.rready)
      ifu_got.push_back(ifu_bus.r[R_W-1 -: DATA_W]);
    // Advance the model across the coming rising edge.
    if (reset) begin
      owner    = NONE;
      last_win = LSU;
    end else if (owner == NONE) begin
      if (arv == 2'b11)   owner = RR_EN ? ((last_win == LSU) ? IFU : LSU) : LSU;
      else if (arv[IFU])  owner = IFU;
      else if (arv[LSU])  owner = LSU;
      if (owner != NONE) begin
        in_addr  = 1'b1;
        last_win = owner;
      end
    end else if (in_addr) begin
      if (!arv[owner])          owner = NONE;
      else if (mem_bus.arready) in_addr = 1'b0;
    end else if (mem_bus.rvalid && rrd[owner] && mem_bus.r[2]) begin
      owner = NONE;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Puts IFU into its data phase for a 4-beat burst at 0x3000_0010.
  task automatic start_ifu_burst();
    ifu_bus.ar      = mk_ar(32'h3000_0010, 8'd3);
    ifu_bus.arvalid = 1'b1;
    tick();
    mem_bus.arready = 1'b1;
    #1 check("burst_io_arvalid", 64'(mem_bus.arvalid), 64'd1);
    check("burst_io_ar", 64'(mem_bus.ar), 64'(mk_ar(32'h3000_0010, 8'd3)));
    tick();
    ifu_bus.arvalid = 1'b0;
    mem_bus.arready = 1'b0;
    ifu_bus.rready  = 1'b1;
  endtask

  logic [31:0] burst_data[4];

  initial begin
    burst_data[0] = 32'h11; burst_data[1] = 32'h22;
    burst_data[2] = 32'h33; burst_data[3] = 32'h44;

    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1;
    tick();
    reset = 1'b0;
    check("reset_grant", 64'(grant), 64'd0);
    check("reset_busy",  64'(busy),  64'd0);

    // IFU alone: 4-beat burst delivered in order, grant held until last.
    ifu_got.delete();
    start_ifu_burst();
    mem_bus.rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_bus.r = mk_r(burst_data[i], i == 3);
      #1 check("s1_grant_hold", 64'(grant), 64'b01);
      tick();
    end
    mem_bus.rvalid = 1'b0;
    #1 check("s1_grant_after_last", 64'(grant), 64'b00);
    check("s1_beats", 64'(ifu_got.size()), 64'd4);
    for (int i = 0; i < 4 && i < ifu_got.size(); i++)
      check("s1_data", 64'(ifu_got[i]), 64'(burst_data[i]));
    idle_inputs();
    tick();

    // Simultaneous requests after reset.
    reset_dut();
    ifu_bus.ar = mk_ar(32'h3000_0020, 8'd3); ifu_bus.arvalid = 1'b1;
    lsu_bus.ar = mk_ar(32'h8000_0100, 8'd0); lsu_bus.arvalid = 1'b1;
    #1 check("s2_grant_idle", 64'(grant), 64'b00);
    tick();
    #1 check("s2_tie_grant", 64'(grant), 64'(TIE_FIRST));
    mem_bus.arready = 1'b1;
    tick();
    if (TIE_FIRST == 2'b10) lsu_bus.arvalid = 1'b0;
    else                    ifu_bus.arvalid = 1'b0;
    mem_bus.arready = 1'b0;
    mem_bus.rvalid  = 1'b1;
    mem_bus.r       = mk_r(32'hDEAD_BEEF, 1'b1);
    lsu_bus.rready  = 1'b1;
    ifu_bus.rready  = 1'b1;
    #1 check("s2_lsu_rdata", 64'(lsu_bus.r[R_W-1 -: DATA_W]), 64'hDEAD_BEEF);
    tick();
    mem_bus.rvalid = 1'b0;
    #1 check("s2_idle_after_last", 64'(grant), 64'b00);
    tick();
    #1 check("s2_second_grant", 64'(grant), 64'(TIE_SECOND));
    idle_inputs();
    tick();
    tick();

    // LSU request arriving mid-burst waits for rlast.
    reset_dut();
    start_ifu_burst();
    lsu_bus.ar = mk_ar(32'h8000_0200, 8'd0); lsu_bus.arvalid = 1'b1;
    mem_bus.arready = 1'b1;
    mem_bus.rvalid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_bus.r = mk_r(burst_data[i], i == 3);
      #1 check("s3_lsu_arready", 64'(lsu_bus.arready), 64'd0);
      check("s3_lsu_rvalid", 64'(lsu_bus.rvalid), 64'd0);
      tick();
    end
    mem_bus.rvalid  = 1'b0;
    mem_bus.arready = 1'b0;
    #1 check("s3_idle_after_last", 64'(grant), 64'b00);
    tick();
    #1 check("s3_lsu_grant", 64'(grant), 64'b10);
    idle_inputs();
    tick();

    // IFU flush before the AR handshake.
    reset_dut();
    ifu_bus.ar = mk_ar(32'h3000_0040, 8'd3); ifu_bus.arvalid = 1'b1;
    tick();
    #1 check("s4_grant", 64'(grant), 64'b01);
    tick();
    ifu_bus.arvalid = 1'b0;
    #1 check("s4_io_arvalid_drop", 64'(mem_bus.arvalid), 64'd0);
    tick();
    #1 check("s4_grant_released", 64'(grant), 64'b00);
    check("s4_busy", 64'(busy), 64'd0);

    // IFU stalls three cycles on beat 2; no beat lost or duplicated.
    ifu_got.delete();
    start_ifu_burst();
    mem_bus.rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_bus.r = mk_r(burst_data[i], i == 3);
      if (i == 1) begin
        ifu_bus.rready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1 check("s5_stall_rready", 64'(mem_bus.rready), 64'd0);
          tick();
        end
        ifu_bus.rready = 1'b1;
      end
      tick();
    end
    mem_bus.rvalid = 1'b0;
    check("s5_beats", 64'(ifu_got.size()), 64'd4);
    for (int i = 0; i < 4 && i < ifu_got.size(); i++)
      check("s5_data", 64'(ifu_got[i]), 64'(burst_data[i]));
    idle_inputs();
    tick();

    // Reset during beat 2, then a fresh LSU transaction.
    start_ifu_burst();
    mem_bus.rvalid = 1'b1;
    mem_bus.r = mk_r(burst_data[0], 1'b0);
    tick();
    mem_bus.r = mk_r(burst_data[1], 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 check("s6_busy", 64'(busy), 64'd0);
    check("s6_grant", 64'(grant), 64'b00);
    check("s6_ifu_rvalid", 64'(ifu_bus.rvalid), 64'd0);
    check("s6_io_rready", 64'(mem_bus.rready), 64'd0);
    idle_inputs();
    lsu_bus.ar = mk_ar(32'h8000_0300, 8'd0); lsu_bus.arvalid = 1'b1;
    tick();
    #1 check("s6_lsu_grant", 64'(grant), 64'b10);
    mem_bus.arready = 1'b1;
    tick();
    lsu_bus.arvalid = 1'b0; mem_bus.arready = 1'b0;
    lsu_bus.rready  = 1'b1; mem_bus.rvalid  = 1'b1;
    mem_bus.r = mk_r(32'hCAFE_F00D, 1'b1);
    #1 check("s6_lsu_rvalid", 64'(lsu_bus.rvalid), 64'd1);
    tick();
    #1 check("s6_done", 64'(grant), 64'b00);
    idle_inputs();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      reset           = ($urandom_range(0, 99) == 0);
      ifu_bus.arvalid = ($urandom_range(0, 2) != 0);
      lsu_bus.arvalid = ($urandom_range(0, 2) != 0);
      ifu_bus.rready  = ($urandom_range(0, 3) != 0);
      lsu_bus.rready  = ($urandom_range(0, 3) != 0);
      mem_bus.arready = $urandom_range(0, 1) == 1;
      mem_bus.rvalid  = $urandom_range(0, 1) == 1;
      ifu_bus.ar      = AR_W'({$urandom(), $urandom()});
      lsu_bus.ar      = AR_W'({$urandom(), $urandom()});
      mem_bus.r       = R_W'({$urandom(), $urandom()});
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
